button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
Collects single-cycle press pulses from the per-button debouncers and serialises them into one ordered event stream for the game FSM. Pending presses are latched per button. When several are pending, a round-robin arbiter grants one per cycle into a small event FIFO. The game FSM consumes events over a valid/ready handshake, so no press is lost while the FSM is busy drawing or checking a puzzle.

Parameters:
N_BTN, 5, number of button edge inputs (one per debouncer instance)
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
ID_W, 3, event id width; must satisfy 2**ID_W >= N_BTN

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous reset, active-high
btn_edge  in  N_BTN  one-cycle press pulses, bit i from debouncer i
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_id  out  ID_W  button index of head event
evt_count  out  $clog2(FIFO_DEPTH)+1  events currently in FIFO
overflow  out  1  sticky: a press was merged or dropped
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (rst=1 at posedge): pending=0, rr_ptr=0, FIFO empty, evt_valid=0, evt_id=0, evt_count=0, overflow=0. Reset overrides all other activity, including mid-handshake; in-flight events are discarded.
- Pending latch: pending[i] is set at the posedge where btn_edge[i]=1.
- Grant (combinational from registered pending and count):
  - If pending!=0 and evt_count<FIFO_DEPTH, grant the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_BTN.
  - At that posedge: push the grant index, clear pending[grant], set rr_ptr=(grant+1) mod N_BTN.
  - At most one push per cycle.
- Same-cycle edge on the granted button: pending stays set. Set wins over clear; the new press is queued later.
- Merge: btn_edge[i]=1 while pending[i]=1 and i not granted this cycle. The press is merged (single pending) and overflow sets.
- Full: push is gated on registered evt_count<FIFO_DEPTH. No push when full, even if a pop occurs that same cycle. Pending presses wait without loss.
- Pop: occurs when evt_valid && evt_ready. Head advances next cycle.
  - evt_id and evt_valid are registered and stay stable while evt_valid && !evt_ready.
  - evt_ready with evt_valid=0 is ignored.
- Simultaneous push and pop (not full): evt_count unchanged; order preserved.
- Latency: edge at posedge k, pending visible after k, push at k+1, evt_valid=1 after k+1. This is 2 cycles into an empty FIFO.
- evt_valid = (evt_count!=0).
- Pointers wrap modulo FIFO_DEPTH. evt_count is a 0..FIFO_DEPTH binary count, never wraps.
- overflow: set wins over clr_overflow in the same cycle. Otherwise clr_overflow clears it.

Decomposition:
- Shared package btn_pkg holds:
  - N_BTN
  - button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_SEL=4
  - ID_W
- Sub-module event_fifo (parameterised DEPTH, WIDTH):
  - push/pop, registered head, count
  - synchronous active-high reset
- Arbiter and pending logic stay in button_event_arbiter.

Test Plan:
- Single press: btn_edge=5'b00100 for 1 cycle from reset -> evt_valid=1 exactly 2 cycles later with evt_id=2. Pulse evt_ready -> evt_valid=0 next cycle, evt_count=0.
- Round-robin: btn_edge=5'b10101 in one cycle, evt_ready=1 -> ids 0,2,4 in order. Then btn_edge=5'b00011 twice with rr_ptr=0 -> 0,1. Repeat with rr_ptr=1 -> 1,0.
- Back-pressure: evt_ready=0, five presses on buttons 0..4 -> evt_count saturates at 4, pending[4] held, evt_id=0 stable. Release evt_ready -> all five drained, id 4 last, overflow=0.
- Merge: evt_ready=0, FIFO full, two presses on button 3 -> overflow=1, only one id-3 event emitted. clr_overflow -> overflow=0. clr_overflow together with a new merge -> overflow stays 1.
- Set-wins: btn_edge[1] asserted in the cycle button 1 is granted -> two id-1 events emitted.
- Reset mid-operation: 3 events queued plus 2 pending, assert rst one cycle -> next cycle evt_valid=0, evt_count=0, overflow=0. A later press on button 4 -> id 4 after 2 cycles.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared button indices and event sizing
//
// Purpose: constants shared by the button event path. Button indices match
// the debouncer instance order; the event id is the button index.
// Ports: none (package).
package btn_pkg;

  localparam int N_BTN      = 5;
  localparam int ID_W       = 3;
  localparam int FIFO_DEPTH = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;

  typedef logic [ID_W-1:0] btn_id_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - small synchronous FIFO with registered head
//
// Purpose: holds granted button events until the consumer takes them.
// The head entry is kept in its own register so the output id is a
// flop, stable while the consumer stalls.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         write push_data (ignored when full)
//   push_data    entry to append
//   pop          consume the head entry (ignored when empty)
//   valid        head holds an entry (count != 0)
//   head         head entry
//   count        entries stored, 0..DEPTH
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [PW-1:0]    wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] head_q, head_n;
  logic             push_ok, pop_ok;

  assign push_ok = push && (cnt != FULL_CNT);
  assign pop_ok  = pop  && (cnt != '0);

  always_comb begin
    mem_n    = mem;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    cnt_n    = cnt;
    if (push_ok) begin
      mem_n[wr_ptr] = push_data;
      wr_ptr_n      = wr_ptr + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_n = rd_ptr + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      cnt_n = cnt + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_n = cnt - CW'(1);
    end
    // Head is looked up from the post-update storage so a push into an
    // empty FIFO is visible on the very next cycle.
    head_n = mem_n[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
    end else begin
      mem    <= mem_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      cnt    <= cnt_n;
      head_q <= head_n;
    end
  end

  assign valid = (cnt != '0);
  assign head  = head_q;
  assign count = cnt;

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - serialise button presses into one event stream
//
// Purpose: latches one-cycle press pulses per button, picks one pending
// button per cycle in round-robin order and queues its index for the game
// FSM, which drains events over a valid/ready handshake.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   btn_edge       one-cycle press pulses, bit i from debouncer i
//   evt_valid      head event present
//   evt_ready      consumer takes the head event this cycle
//   evt_id         button index of the head event
//   evt_count      events currently queued
//   overflow       sticky flag: a press was merged into an already pending one
//   clr_overflow   clears overflow (a same-cycle merge still sets it)
module button_event_arbiter #(
  parameter int N_BTN      = btn_pkg::N_BTN,
  parameter int FIFO_DEPTH = btn_pkg::FIFO_DEPTH,
  parameter int ID_W       = btn_pkg::ID_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BTN-1:0]              btn_edge,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [ID_W-1:0]               evt_id,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  import btn_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_BTN - 1);

  logic [N_BTN-1:0] pending, pending_n, grant_oh;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_n, grant_idx;
  logic [ID_W-1:0]  hi_idx, lo_idx;
  logic             hi_found, lo_found;
  logic             grant_valid, merge, overflow_n;
  logic [CW-1:0]    fifo_count;

  // Circular scan from rr_ptr: the lowest pending index at or above rr_ptr
  // wins; if none, the scan has wrapped and the lowest pending index wins.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    // Gate on the registered count only: a pop in the same cycle does not
    // open a slot until the next cycle.
    grant_valid = lo_found && (fifo_count != FULL_CNT);
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_BTN; i++) begin
      grant_oh[i] = grant_valid && (grant_idx == ID_W'(i));
    end
    // A new edge on the button being granted re-arms it (set wins), so
    // that press becomes a second event rather than a merge.
    pending_n = (pending & ~grant_oh) | btn_edge;
    merge     = |(btn_edge & pending & ~grant_oh);

    rr_ptr_n = rr_ptr;
    if (grant_valid) begin
      rr_ptr_n = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
    end

    overflow_n = overflow;
    if (merge) begin
      overflow_n = 1'b1;
    end else if (clr_overflow) begin
      overflow_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_n;
      rr_ptr   <= rr_ptr_n;
      overflow <= overflow_n;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (grant_idx),
    .pop       (evt_ready),
    .valid     (evt_valid),
    .head      (evt_id),
    .count     (fifo_count)
  );

  assign evt_count = fifo_count;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

  import btn_pkg::*;

  localparam int NB    = 5;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NB-1:0]  btn_edge;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic [CW-1:0]  evt_count;
  logic           overflow;
  logic           clr_overflow;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN      (NB),
    .FIFO_DEPTH (DEPTH),
    .ID_W       (IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_edge     (btn_edge),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending presses as a bit array, the FIFO as a queue.
  bit m_pend [NB];
  int m_q [$];
  int m_rr;
  bit m_ovf;

  int popped [$];
  int exp_ids [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [NB-1:0] e, input bit r, input bit c, input bit rs);
    int g;
    bit gv;
    bit mrg;
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_q.delete();
      m_rr  = 0;
      m_ovf = 1'b0;
      return;
    end
    gv = 1'b0;
    g  = 0;
    if (m_q.size() < DEPTH) begin
      for (int k = 0; k < NB; k++) begin
        int idx;
        idx = (m_rr + k) % NB;
        if (!gv && m_pend[idx]) begin
          gv = 1'b1;
          g  = idx;
        end
      end
    end
    mrg = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (e[i] && m_pend[i] && !(gv && g == i)) mrg = 1'b1;
    end
    if (gv) m_pend[g] = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (e[i]) m_pend[i] = 1'b1;
    end
    if (r && m_q.size() != 0) void'(m_q.pop_front());
    if (gv) begin
      m_q.push_back(g);
      m_rr = (g + 1) % NB;
    end
    if (mrg) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic [NB-1:0] e, input bit r, input bit c, input bit rs);
    btn_edge     = e;
    evt_ready    = r;
    clr_overflow = c;
    rst          = rs;
    if (!rs && r && evt_valid === 1'b1) popped.push_back(int'(evt_id));
    model_step(e, r, c, rs);
    @(posedge clk);
    #1;
    chk("model_valid", evt_valid, m_q.size() != 0);
    chk("model_count", evt_count, m_q.size());
    chk("model_overflow", overflow, m_ovf);
    if (m_q.size() != 0) chk("model_id", evt_id, m_q[0]);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) cycle('0, r, 1'b0, 1'b0);
  endtask

  task automatic check_popped(input string tag);
    chk({tag, "_len"}, popped.size(), exp_ids.size());
    for (int i = 0; i < popped.size() && i < exp_ids.size(); i++) begin
      chk(tag, popped[i], exp_ids[i]);
    end
    popped.delete();
  endtask

  initial begin
    rst          = 1'b1;
    btn_edge     = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_rr  = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_id", evt_id, 0);

    // Single press: two-cycle latency into an empty FIFO
    cycle(5'b00100, 1'b0, 1'b0, 1'b0);
    chk("lat1_valid", evt_valid, 0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("lat2_valid", evt_valid, 1);
    chk("lat2_id", evt_id, BTN_LEFT);
    cycle('0, 1'b1, 1'b0, 1'b0);
    chk("pop_valid", evt_valid, 0);
    chk("pop_count", evt_count, 0);
    exp_ids = '{2};
    check_popped("single");

    // Bring rr_ptr back to 0 via button 4
    cycle(5'b10000, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    exp_ids = '{4};
    check_popped("rr_pre");

    // Round-robin
    cycle(5'b10101, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);
    exp_ids = '{0, 2, 4};
    check_popped("rr_a");
    cycle(5'b00011, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    exp_ids = '{0, 1};
    check_popped("rr_b");
    cycle(5'b00001, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    exp_ids = '{0};
    check_popped("rr_c");
    cycle(5'b00011, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    exp_ids = '{1, 0};
    check_popped("rr_d");

    // Back-pressure (rr_ptr is 1; press 4 to return it to 0)
    cycle(5'b10000, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    popped.delete();
    cycle(5'b11111, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("bp_count", evt_count, 4);
    chk("bp_id", evt_id, 0);
    idle(2, 1'b0);
    chk("bp_id_stable", evt_id, 0);
    idle(12, 1'b1);
    exp_ids = '{0, 1, 2, 3, 4};
    check_popped("bp_drain");
    chk("bp_overflow", overflow, 0);

    // Merge while full
    cycle(5'b10111, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    cycle(5'b01000, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(5'b01000, 1'b0, 1'b0, 1'b0);
    chk("merge_overflow", overflow, 1);
    idle(10, 1'b1);
    exp_ids = '{0, 1, 2, 4, 3};
    check_popped("merge_drain");
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("clr_overflow", overflow, 0);

    // clr_overflow together with a merge: set wins
    cycle(5'b01111, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    cycle(5'b00010, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(5'b00010, 1'b0, 1'b1, 1'b0);
    chk("set_wins_overflow", overflow, 1);
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("clr2_overflow", overflow, 0);
    idle(10, 1'b1);
    exp_ids = '{0, 1, 2, 3, 1};
    check_popped("clrmerge_drain");

    // Edge on the granted button re-arms it
    cycle(5'b00010, 1'b1, 1'b0, 1'b0);
    cycle(5'b00010, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);
    exp_ids = '{1, 1};
    check_popped("setwin");
    chk("setwin_overflow", overflow, 0);

    // Reset mid-operation
    cycle(5'b11111, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("rm_count", evt_count, 3);
    cycle(5'b00010, 1'b0, 1'b0, 1'b0);
    chk("rm_overflow_pre", overflow, 1);
    cycle('0, 1'b1, 1'b0, 1'b1);
    chk("rm_valid", evt_valid, 0);
    chk("rm_count0", evt_count, 0);
    chk("rm_overflow", overflow, 0);
    cycle(5'b10000, 1'b0, 1'b0, 1'b0);
    chk("rm_lat1_valid", evt_valid, 0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("rm_lat2_valid", evt_valid, 1);
    chk("rm_lat2_id", evt_id, BTN_SEL);
    idle(2, 1'b1);
    popped.delete();

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [NB-1:0] e;
      bit r, c, rs;
      e  = NB'($urandom_range(0, 31) & $urandom_range(0, 31));
      r  = ($urandom_range(0, 3) != 0);
      if ((n / 100) % 2 == 1) r = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cycle(e, r, c, rs);
    end
    popped.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
